// File: rtl/r5fp_fma_issue_sched.sv
// Two-requester round-robin issue onto one shared stall-free R5FP FMA pipeline, with a credit-protected result FIFO.
// Optional synchronous flush port is enabled by defining R5FP_SCHED_FLUSH_EN.
`default_nettype none

module r5fp_fma_issue_sched #(
  parameter int EXP_W = 11,
  parameter int SIG_W = 52,
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  localparam int OP_W = EXP_W + SIG_W + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      rq_vld,
  output logic [1:0]      rq_rdy,
  input  logic [OP_W-1:0] rq_a0,
  input  logic [OP_W-1:0] rq_b0,
  input  logic [OP_W-1:0] rq_c0,
  input  logic [2:0]      rq_rnd0,
  input  logic [OP_W-1:0] rq_a1,
  input  logic [OP_W-1:0] rq_b1,
  input  logic [OP_W-1:0] rq_c1,
  input  logic [2:0]      rq_rnd1,
  output logic            fma_vld,
  output logic [OP_W-1:0] fma_a,
  output logic [OP_W-1:0] fma_b,
  output logic [OP_W-1:0] fma_c,
  output logic [2:0]      fma_rnd,
  input  logic [OP_W-1:0] fma_z,
  input  logic [7:0]      fma_st,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [OP_W-1:0] res_z,
  output logic [7:0]      res_st,
  output logic            res_id,
  output logic            busy
`ifdef R5FP_SCHED_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic flushNow;
`ifdef R5FP_SCHED_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  logic [CNT_W-1:0] inflightReg;
  logic [CNT_W-1:0] fifoCntReg;
  logic [CNT_W-1:0] occ;
  logic             issueOk;
  logic             prioReg;
  logic [1:0]       grant;
  logic [1:0]       accept;
  logic             acceptAny;
  logic             acceptId;

  // occ counts every op that will eventually need a FIFO slot, so a push can never find the FIFO full
  assign occ     = inflightReg + fifoCntReg;
  assign issueOk = rst_n & ~flushNow & (occ < CNT_W'(DEPTH));

  always_comb begin
    grant = 2'b00;
    unique case (rq_vld)
      2'b11:   grant = prioReg ? 2'b10 : 2'b01;
      default: grant = rq_vld;
    endcase
  end

  assign rq_rdy    = grant & {2{issueOk}};
  assign accept    = rq_vld & rq_rdy;
  assign acceptAny = |accept;
  assign acceptId  = accept[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prioReg <= 1'b0;
    end else if (acceptAny) begin
      prioReg <= ~acceptId;
    end
  end

  logic [OP_W-1:0] selA;
  logic [OP_W-1:0] selB;
  logic [OP_W-1:0] selC;
  logic [2:0]      selRnd;

  assign selA   = acceptId ? rq_a1   : rq_a0;
  assign selB   = acceptId ? rq_b1   : rq_b0;
  assign selC   = acceptId ? rq_c1   : rq_c0;
  assign selRnd = acceptId ? rq_rnd1 : rq_rnd0;

  logic            fmaVldReg;
  logic            fmaIdReg;
  logic [OP_W-1:0] fmaAReg;
  logic [OP_W-1:0] fmaBReg;
  logic [OP_W-1:0] fmaCReg;
  logic [2:0]      fmaRndReg;

  // Operand registers hold their last value between issues; only the strobe pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmaVldReg <= 1'b0;
      fmaIdReg  <= 1'b0;
      fmaAReg   <= '0;
      fmaBReg   <= '0;
      fmaCReg   <= '0;
      fmaRndReg <= '0;
    end else begin
      fmaVldReg <= acceptAny;
      if (acceptAny) begin
        fmaIdReg  <= acceptId;
        fmaAReg   <= selA;
        fmaBReg   <= selB;
        fmaCReg   <= selC;
        fmaRndReg <= selRnd;
      end
    end
  end

  assign fma_vld = fmaVldReg;
  assign fma_a   = fmaAReg;
  assign fma_b   = fmaBReg;
  assign fma_c   = fmaCReg;
  assign fma_rnd = fmaRndReg;

  // Tracking pipe: stage gi holds the op issued gi+1 cycles before its fma_z becomes valid minus one
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_trk
      logic vldIn;
      logic idIn;
      logic vldReg;
      logic idReg;
      if (gi == 0) begin : g_head
        assign vldIn = fmaVldReg;
        assign idIn  = fmaIdReg;
      end else begin : g_body
        assign vldIn = g_trk[gi-1].vldReg;
        assign idIn  = g_trk[gi-1].idReg;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vldReg <= 1'b0;
          idReg  <= 1'b0;
        end else begin
          vldReg <= vldIn & ~flushNow;
          idReg  <= idIn;
        end
      end
    end
  endgenerate

  logic push;
  logic pushId;
  logic pop;

  assign push    = g_trk[LAT-1].vldReg & ~flushNow;
  assign pushId  = g_trk[LAT-1].idReg;
  assign res_vld = (fifoCntReg != '0);
  assign pop     = res_rdy & res_vld;

  logic [OP_W-1:0]  memZ  [DEPTH];
  logic [7:0]       memSt [DEPTH];
  logic             memId [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;

  always_ff @(posedge clk) begin
    if (push) begin
      memZ[wrPtrReg]  <= fma_z;
      memSt[wrPtrReg] <= fma_st;
      memId[wrPtrReg] <= pushId;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      inflightReg <= '0;
      fifoCntReg  <= '0;
    end else if (flushNow) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      inflightReg <= '0;
      fifoCntReg  <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      inflightReg <= inflightReg + CNT_W'(acceptAny) - CNT_W'(push);
      fifoCntReg  <= fifoCntReg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign res_z  = memZ[rdPtrReg];
  assign res_st = memSt[rdPtrReg];
  assign res_id = memId[rdPtrReg];
  assign busy   = (inflightReg != '0) | (fifoCntReg != '0);

`ifndef SYNTHESIS
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifoCntReg == CNT_W'(DEPTH))));
  a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
    occ <= CNT_W'(DEPTH));
  a_rdy_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    rq_rdy != 2'b11);
`endif

endmodule

`default_nettype wire

// File: tb/tb_r5fp_fma_issue_sched.sv
// Self-checking bench for r5fp_fma_issue_sched: arbitration table, latency/credit/reset corner sequences,
// and a randomized run checked against a queue-based reference model. Flush test when R5FP_SCHED_FLUSH_EN is defined.
`timescale 1ns/1ps

module tb_r5fp_fma_issue_sched;
  localparam int EXP_W = 11;
  localparam int SIG_W = 52;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int OP_W  = EXP_W + SIG_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      rqVld;
  logic [1:0]      rqRdy;
  logic [OP_W-1:0] opA [2];
  logic [OP_W-1:0] opB [2];
  logic [OP_W-1:0] opC [2];
  logic [2:0]      opR [2];
  logic            fmaVld;
  logic [OP_W-1:0] fmaA, fmaB, fmaC, fmaZ;
  logic [2:0]      fmaRnd;
  logic [7:0]      fmaSt;
  logic            resVld, resRdy, resId, busy;
  logic [OP_W-1:0] resZ;
  logic [7:0]      resSt;
  logic            flushTb;

  r5fp_fma_issue_sched #(.EXP_W(EXP_W), .SIG_W(SIG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_vld(rqVld), .rq_rdy(rqRdy),
    .rq_a0(opA[0]), .rq_b0(opB[0]), .rq_c0(opC[0]), .rq_rnd0(opR[0]),
    .rq_a1(opA[1]), .rq_b1(opB[1]), .rq_c1(opC[1]), .rq_rnd1(opR[1]),
    .fma_vld(fmaVld), .fma_a(fmaA), .fma_b(fmaB), .fma_c(fmaC), .fma_rnd(fmaRnd),
    .fma_z(fmaZ), .fma_st(fmaSt),
    .res_vld(resVld), .res_rdy(resRdy), .res_z(resZ), .res_st(resSt), .res_id(resId),
    .busy(busy)
`ifdef R5FP_SCHED_FLUSH_EN
    , .flush(flushTb)
`endif
  );

  // Stand-in datapath: arbitrary function of the operands, garbage whenever no op is due
  function automatic logic [OP_W-1:0] fz(input logic [OP_W-1:0] a, b, c, input logic [2:0] r);
    return (a ^ {b[31:0], b[63:32]}) + c + OP_W'(r);
  endfunction
  function automatic logic [7:0] fst(input logic [OP_W-1:0] a, c, input logic [2:0] r);
    return a[7:0] ^ c[15:8] ^ {5'b0, r};
  endfunction

  logic [OP_W-1:0] zPipe [LAT];
  logic [7:0]      sPipe [LAT];
  always @(posedge clk) begin
    zPipe[0] <= fmaVld ? fz(fmaA, fmaB, fmaC, fmaRnd) : {$urandom, $urandom};
    sPipe[0] <= fmaVld ? fst(fmaA, fmaC, fmaRnd) : 8'($urandom);
    for (int k = 1; k < LAT; k++) begin
      zPipe[k] <= zPipe[k-1];
      sPipe[k] <= sPipe[k-1];
    end
  end
  assign fmaZ  = zPipe[LAT-1];
  assign fmaSt = sPipe[LAT-1];

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted op is owed one result, in acceptance order, LAT+2 cycles later
  typedef struct {
    logic            id;
    logic [OP_W-1:0] z;
    logic [7:0]      st;
    int              due;
  } exp_t;

  exp_t             expQ[$];
  int               cyc = 0;
  logic             mPrio = 1'b0;
  logic             mPrevAcc = 1'b0;
  logic [3*OP_W+2:0] mPrevOps = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_rq_rdy", 200'(rqRdy), 200'(0));
        check("rst_fma_vld", 200'(fmaVld), 200'(0));
        check("rst_fma_ops", 200'({fmaA, fmaB, fmaC, fmaRnd}), 200'(0));
        check("rst_res_vld", 200'(resVld), 200'(0));
        check("rst_busy", 200'(busy), 200'(0));
        expQ.delete();
        mPrio    = 1'b0;
        mPrevAcc = 1'b0;
      end else begin
        logic [1:0] eRdy;
        logic       eResVld;
        eRdy = 2'b00;
        if (expQ.size() < DEPTH && !flushTb) begin
          if (rqVld == 2'b11) eRdy = mPrio ? 2'b10 : 2'b01;
          else                eRdy = rqVld;
        end
        check("rq_rdy", 200'(rqRdy), 200'(eRdy));
        check("fma_vld", 200'(fmaVld), 200'(mPrevAcc));
        if (mPrevAcc) check("fma_ops", 200'({fmaA, fmaB, fmaC, fmaRnd}), 200'(mPrevOps));
        eResVld = (expQ.size() > 0) && (expQ[0].due <= cyc);
        check("res_vld", 200'(resVld), 200'(eResVld));
        check("busy", 200'(busy), 200'(expQ.size() > 0));
        if (eResVld && resRdy) begin
          check("res_z", 200'(resZ), 200'(expQ[0].z));
          check("res_st", 200'(resSt), 200'(expQ[0].st));
          check("res_id", 200'(resId), 200'(expQ[0].id));
          $display("pop  id=%0d z=%h st=%h cycle=%0d", expQ[0].id, expQ[0].z, expQ[0].st, cyc);
          void'(expQ.pop_front());
        end
        mPrevAcc = 1'b0;
        if (flushTb) begin
          expQ.delete();
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (rqVld[i] && eRdy[i]) begin
              exp_t e;
              e.id  = (i == 1);
              e.z   = fz(opA[i], opB[i], opC[i], opR[i]);
              e.st  = fst(opA[i], opC[i], opR[i]);
              e.due = cyc + LAT + 2;
              expQ.push_back(e);
              mPrevAcc = 1'b1;
              mPrevOps = {opA[i], opB[i], opC[i], opR[i]};
              mPrio    = (i == 0);
            end
          end
        end
      end
    end
  end

  // Driver helpers: inputs change only at posedge+1; DUT values are snapshotted at negedge
  logic [1:0]      lastAcc = 2'b00;
  logic [1:0]      snapRdy;
  logic            snapBusy, snapResVld, snapFmaVld, snapResId;
  logic [OP_W-1:0] snapResZ, snapFmaZ;

  task automatic newOps(input int i);
    opA[i] = {$urandom, $urandom};
    opB[i] = {$urandom, $urandom};
    opC[i] = {$urandom, $urandom};
    opR[i] = 3'($urandom);
  endtask

  task automatic tick();
    @(negedge clk);
    lastAcc    = rqVld & rqRdy;
    snapRdy    = rqRdy;
    snapBusy   = busy;
    snapResVld = resVld;
    snapFmaVld = fmaVld;
    snapResId  = resId;
    snapResZ   = resZ;
    snapFmaZ   = fmaZ;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (lastAcc[i]) newOps(i);
  endtask

  task automatic waitIdle();
    int k;
    rqVld  = 2'b00;
    resRdy = 1'b1;
    for (k = 0; k < 200 && busy; k++) tick();
    check("idle_timeout", 200'(busy), 200'(0));
  endtask

  task automatic issueN(input logic [1:0] vld, input int n, input string name);
    int got;
    got   = 0;
    rqVld = vld;
    for (int k = 0; k < 40 && got < n; k++) begin
      tick();
      got += int'(lastAcc[0]) + int'(lastAcc[1]);
    end
    rqVld = 2'b00;
    check(name, 200'(got), 200'(n));
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [1:0] expRdy;
    logic       expBusy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int nAcc, seen;
    logic [OP_W-1:0] zAt, zSeen;
    logic idSeen;

    tbl[0]  = '{2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 2'b01, 1'b0};
    tbl[2]  = '{2'b11, 2'b10, 1'b1};
    tbl[3]  = '{2'b01, 2'b01, 1'b1};
    tbl[4]  = '{2'b01, 2'b01, 1'b1};
    tbl[5]  = '{2'b11, 2'b10, 1'b1};
    tbl[6]  = '{2'b11, 2'b01, 1'b1};
    tbl[7]  = '{2'b10, 2'b10, 1'b1};
    tbl[8]  = '{2'b10, 2'b10, 1'b1};
    tbl[9]  = '{2'b11, 2'b01, 1'b1};
    tbl[10] = '{2'b11, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 1'b1};

    rst_n   = 1'b1;
    rqVld   = 2'b00;
    resRdy  = 1'b0;
    flushTb = 1'b0;
    newOps(0);
    newOps(1);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Arbitration table straight out of reset
    resRdy = 1'b1;
    for (int v = 0; v < 12; v++) begin
      rqVld = tbl[v].vld;
      tick();
      check($sformatf("tbl%0d_rdy", v), 200'(snapRdy), 200'(tbl[v].expRdy));
      check($sformatf("tbl%0d_busy", v), 200'(snapBusy), 200'(tbl[v].expBusy));
    end
    waitIdle();

    // Single op latency
    rqVld = 2'b01;
    tick();
    check("a_rdy", 200'(snapRdy), 200'(2'b01));
    rqVld = 2'b00;
    seen = 0; zAt = '0; zSeen = '0; idSeen = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) check("a_fma_vld", 200'(snapFmaVld), 200'(1));
      if (k == LAT + 1) zAt = snapFmaZ;
      if (snapResVld && seen == 0) begin
        seen = k; zSeen = snapResZ; idSeen = snapResId;
      end
    end
    check("a_latency", 200'(seen), 200'(LAT + 2));
    check("a_res_z", 200'(zSeen), 200'(zAt));
    check("a_res_id", 200'(idSeen), 200'(0));
    waitIdle();

    // Credit exhaustion under backpressure, then one pop releases exactly one issue
    resRdy = 1'b0;
    rqVld  = 2'b01;
    nAcc   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      nAcc += int'(lastAcc[0]);
    end
    check("b_accepts", 200'(nAcc), 200'(DEPTH));
    check("b_blocked", 200'(snapRdy), 200'(0));
    resRdy = 1'b1;
    tick();
    check("b_pop_cycle_no_acc", 200'(lastAcc), 200'(0));
    resRdy = 1'b0;
    tick();
    check("b_acc_after_pop", 200'(lastAcc), 200'(2'b01));
    nAcc = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      nAcc += int'(lastAcc[0]);
    end
    check("b_no_more", 200'(nAcc), 200'(0));
    waitIdle();

    // FIFO filled to 7, then streaming push/pop so pointers wrap
    resRdy = 1'b0;
    issueN(2'b01, 7, "c_fill");
    repeat (LAT + 2) tick();
    check("c_queued", 200'({snapResVld, snapBusy}), 200'(2'b11));
    resRdy = 1'b1;
    rqVld  = 2'b11;
    repeat (40) tick();
    waitIdle();

    // Reset with 2 queued and 3 in flight
    resRdy = 1'b0;
    issueN(2'b01, 2, "d_queue");
    repeat (LAT + 2) tick();
    issueN(2'b11, 3, "d_inflight");
    rqVld = 2'b11;
    rst_n = 1'b0;
    #1;
    check("d_rst_rdy", 200'(rqRdy), 200'(0));
    check("d_rst_fma", 200'({fmaVld, fmaA, fmaB, fmaC, fmaRnd}), 200'(0));
    check("d_rst_res_vld", 200'(resVld), 200'(0));
    check("d_rst_busy", 200'(busy), 200'(0));
    repeat (2) @(posedge clk);
    #1;
    rqVld = 2'b00;
    rst_n = 1'b1;
    resRdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("d_no_stale", 200'({snapResVld, snapBusy}), 200'(0));
    end

`ifdef R5FP_SCHED_FLUSH_EN
    // Flush with 3 queued and 4 in flight
    resRdy = 1'b0;
    issueN(2'b01, 3, "f_queue");
    repeat (LAT + 2) tick();
    issueN(2'b01, 4, "f_inflight");
    flushTb = 1'b1;
    tick();
    check("f_rdy_during", 200'(snapRdy), 200'(0));
    flushTb = 1'b0;
    check("f_after", 200'({resVld, busy}), 200'(0));
    resRdy = 1'b1;
    issueN(2'b10, 1, "f_new_op");
    waitIdle();
`endif

    // Randomized traffic with alternating backpressure regimes
    rqVld   = 2'b00;
    lastAcc = 2'b00;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++)
        if (!rqVld[i] || lastAcc[i]) rqVld[i] = ($urandom_range(0, 3) != 0);
      resRdy = ((k / 150) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    waitIdle();
    check("end_queue_empty", 200'(expQ.size()), 200'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
